// File: rtl/mmio_copy_master.sv
// Bus-initiator copy engine: moves word_count words from src_addr to dst_addr over the MEM-stage bus.
// Optional COPY_CHECKSUM_EN adds a running mod-2^32 sum of all written words on port checksum.
module mmio_copy_master #(
    parameter int          COUNT_W   = 16,
    parameter int unsigned ADDR_STEP = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [31:0]        src_addr,
    input  logic [31:0]        dst_addr,
    input  logic [COUNT_W-1:0] word_count,
    input  logic               irq_clear,
    input  logic               bus_grant,
    input  logic [31:0]        bus_rd_data,
    output logic [31:0]        bus_addr,
    output logic [31:0]        bus_wr_data,
    output logic               bus_mem_read,
    output logic               bus_mem_write,
    output logic               busy,
    output logic               done,
`ifdef COPY_CHECKSUM_EN
    output logic [31:0]        checksum,
`endif
    output logic               irq
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [31:0]        STEP      = 32'(ADDR_STEP);
    localparam logic [31:0]        WORD_MASK = 32'hFFFF_FFFC;
    localparam logic [COUNT_W-1:0] REM_ZERO  = {COUNT_W{1'b0}};
    localparam logic [COUNT_W-1:0] REM_ONE   = {{(COUNT_W-1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic [31:0]        src_q, src_d;
    logic [31:0]        dst_q, dst_d;
    logic [COUNT_W-1:0] rem_q, rem_d;
    logic [31:0]        buf_q, buf_d;
    logic               irq_q, irq_d;
    logic [31:0]        bus_addr_q, bus_addr_d;
    logic [31:0]        bus_wr_data_q, bus_wr_data_d;
    logic               rd_q, rd_d;
    logic               wr_q, wr_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
`ifdef COPY_CHECKSUM_EN
    logic [31:0]        csum_q, csum_d;
`endif

    // Next-state, datapath and next-output decode; outputs are derived from next state so they register cleanly.
    always_comb begin
        state_d       = state_q;
        src_d         = src_q;
        dst_d         = dst_q;
        rem_d         = rem_q;
        buf_d         = buf_q;
        irq_d         = irq_q;
        bus_addr_d    = 32'h0000_0000;
        bus_wr_data_d = 32'h0000_0000;
        rd_d          = 1'b0;
        wr_d          = 1'b0;
        busy_d        = 1'b0;
        done_d        = 1'b0;
`ifdef COPY_CHECKSUM_EN
        csum_d        = csum_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    src_d = src_addr & WORD_MASK;
                    dst_d = dst_addr & WORD_MASK;
                    rem_d = word_count;
`ifdef COPY_CHECKSUM_EN
                    csum_d = 32'h0000_0000;
`endif
                    if (word_count == REM_ZERO) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_READ;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                if (bus_grant) begin
                    buf_d   = bus_rd_data;
                    state_d = ST_WRITE;
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_WRITE: begin
                if (bus_grant) begin
                    src_d = src_q + STEP;
                    dst_d = dst_q + STEP;
                    rem_d = rem_q - REM_ONE;
`ifdef COPY_CHECKSUM_EN
                    csum_d = csum_q + buf_q;
`endif
                    if (rem_q == REM_ONE) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_READ;
                    end
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Completion sets irq even if a clear arrives in the same cycle.
        if (state_q == ST_DONE) begin
            irq_d = 1'b1;
        end else if (irq_clear) begin
            irq_d = 1'b0;
        end else begin
            irq_d = irq_q;
        end

        case (state_d)
            ST_READ: begin
                bus_addr_d = src_d;
                rd_d       = 1'b1;
                busy_d     = 1'b1;
            end
            ST_WRITE: begin
                bus_addr_d    = dst_d;
                bus_wr_data_d = buf_d;
                wr_d          = 1'b1;
                busy_d        = 1'b1;
            end
            ST_DONE: begin
                done_d = 1'b1;
            end
            ST_IDLE: begin
                done_d = 1'b0;
            end
            default: begin
                done_d = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers; reset aborts any copy immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            src_q         <= 32'h0000_0000;
            dst_q         <= 32'h0000_0000;
            rem_q         <= REM_ZERO;
            buf_q         <= 32'h0000_0000;
            irq_q         <= 1'b0;
            bus_addr_q    <= 32'h0000_0000;
            bus_wr_data_q <= 32'h0000_0000;
            rd_q          <= 1'b0;
            wr_q          <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
`ifdef COPY_CHECKSUM_EN
            csum_q        <= 32'h0000_0000;
`endif
        end else begin
            state_q       <= state_d;
            src_q         <= src_d;
            dst_q         <= dst_d;
            rem_q         <= rem_d;
            buf_q         <= buf_d;
            irq_q         <= irq_d;
            bus_addr_q    <= bus_addr_d;
            bus_wr_data_q <= bus_wr_data_d;
            rd_q          <= rd_d;
            wr_q          <= wr_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
`ifdef COPY_CHECKSUM_EN
            csum_q        <= csum_d;
`endif
        end
    end

    assign bus_addr      = bus_addr_q;
    assign bus_wr_data   = bus_wr_data_q;
    assign bus_mem_read  = rd_q;
    assign bus_mem_write = wr_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign irq           = irq_q;
`ifdef COPY_CHECKSUM_EN
    assign checksum      = csum_q;
`endif

endmodule

// File: tb/tb_mmio_copy_master.sv
// Directed self-checking bench for mmio_copy_master with a combinational-read word memory model.
// Define COPY_CHECKSUM_EN to also exercise the checksum output.
module tb_mmio_copy_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] word_count;
    logic        irq_clear;
    logic        bus_grant;
    logic [31:0] bus_rd_data;
    logic [31:0] bus_addr;
    logic [31:0] bus_wr_data;
    logic        bus_mem_read;
    logic        bus_mem_write;
    logic        busy;
    logic        done;
    logic        irq;
`ifdef COPY_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    mmio_copy_master #(.COUNT_W(16), .ADDR_STEP(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .src_addr      (src_addr),
        .dst_addr      (dst_addr),
        .word_count    (word_count),
        .irq_clear     (irq_clear),
        .bus_grant     (bus_grant),
        .bus_rd_data   (bus_rd_data),
        .bus_addr      (bus_addr),
        .bus_wr_data   (bus_wr_data),
        .bus_mem_read  (bus_mem_read),
        .bus_mem_write (bus_mem_write),
        .busy          (busy),
        .done          (done),
`ifdef COPY_CHECKSUM_EN
        .checksum      (checksum),
`endif
        .irq           (irq)
    );

    always #5 clk = ~clk;

    // Source memory, answered combinationally from the low address bits.
    logic [31:0] init_mem [0:1023];
    assign bus_rd_data = init_mem[bus_addr[11:2]];

    int          wr_cnt     = 0;
    int          strobe_cnt = 0;
    logic [31:0] wr_addr_log [0:63];
    logic [31:0] wr_data_log [0:63];

    // Log every committed write and every strobed cycle.
    always @(posedge clk) begin
        if (bus_mem_write && bus_grant && wr_cnt < 64) begin
            wr_addr_log[wr_cnt] <= bus_addr;
            wr_data_log[wr_cnt] <= bus_wr_data;
            wr_cnt              <= wr_cnt + 1;
        end
        if (bus_mem_read || bus_mem_write) begin
            strobe_cnt <= strobe_cnt + 1;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
        src_addr   = s;
        dst_addr   = d;
        word_count = n;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_done(input int first_cyc, output int cyc);
        cyc = first_cyc;
        while (!done && cyc < 60) begin
            tick();
            cyc++;
        end
        check_val("done_seen", {31'd0, done}, 32'd1);
    endtask

    task automatic pulse_irq_clear();
        irq_clear = 1'b1;
        tick();
        irq_clear = 1'b0;
    endtask

    initial begin
        int cyc;
        int base;
        int s0;

        for (int i = 0; i < 1024; i++) init_mem[i] = 32'h0;
        reset      = 1'b1;
        start      = 1'b0;
        irq_clear  = 1'b0;
        bus_grant  = 1'b1;
        src_addr   = 32'h0;
        dst_addr   = 32'h0;
        word_count = 16'h0;
        tick();
        check_val("rst_addr",  bus_addr, 32'h0);
        check_val("rst_wdata", bus_wr_data, 32'h0);
        check_val("rst_rd",    {31'd0, bus_mem_read}, 32'd0);
        check_val("rst_wr",    {31'd0, bus_mem_write}, 32'd0);
        check_val("rst_busy",  {31'd0, busy}, 32'd0);
        check_val("rst_done",  {31'd0, done}, 32'd0);
        check_val("rst_irq",   {31'd0, irq}, 32'd0);
        reset = 1'b0;
        tick();

        // Basic 3-word copy at full grant.
        init_mem[64] = 32'd1;
        init_mem[65] = 32'd2;
        init_mem[66] = 32'd3;
        base = wr_cnt;
        do_start(32'h100, 32'h200, 16'd3);
        check_val("t1_rd_addr", bus_addr, 32'h100);
        check_val("t1_rd",      {31'd0, bus_mem_read}, 32'd1);
        check_val("t1_busy",    {31'd0, busy}, 32'd1);
        check_val("t1_wd_zero", bus_wr_data, 32'h0);
        tick();
        check_val("t1_wr_addr", bus_addr, 32'h200);
        check_val("t1_wr_data", bus_wr_data, 32'd1);
        check_val("t1_wr",      {31'd0, bus_mem_write}, 32'd1);
        check_val("t1_no_rd",   {31'd0, bus_mem_read}, 32'd0);
        wait_done(2, cyc);
        check_val("t1_latency", cyc, 32'd7);
        check_val("t1_irq_pre", {31'd0, irq}, 32'd0);
        check_val("t1_nwr",     wr_cnt - base, 32'd3);
        for (int i = 0; i < 3; i++) begin
            check_val("t1_log_addr", wr_addr_log[base + i], 32'h200 + 32'(4 * i));
            check_val("t1_log_data", wr_data_log[base + i], 32'(i + 1));
        end
        tick();
        check_val("t1_irq",      {31'd0, irq}, 32'd1);
        check_val("t1_done_off", {31'd0, done}, 32'd0);
        check_val("t1_idle_adr", bus_addr, 32'h0);

        // Zero-length copy.
        pulse_irq_clear();
        check_val("t2_irq_clr", {31'd0, irq}, 32'd0);
        s0 = strobe_cnt;
        do_start(32'h100, 32'h200, 16'd0);
        check_val("t2_done", {31'd0, done}, 32'd1);
        check_val("t2_busy", {31'd0, busy}, 32'd0);
        tick();
        check_val("t2_irq",     {31'd0, irq}, 32'd1);
        check_val("t2_strobes", strobe_cnt - s0, 32'd0);

        // Grant withdrawn for 3 cycles during the first write.
        init_mem[192] = 32'hA;
        init_mem[193] = 32'hB;
        base = wr_cnt;
        do_start(32'h300, 32'h400, 16'd2);
        tick();
        bus_grant = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_val("t3_hold_wr",   {31'd0, bus_mem_write}, 32'd1);
            check_val("t3_hold_addr", bus_addr, 32'h400);
            check_val("t3_hold_data", bus_wr_data, 32'hA);
        end
        bus_grant = 1'b1;
        wait_done(5, cyc);
        check_val("t3_latency", cyc, 32'd8);
        check_val("t3_nwr",     wr_cnt - base, 32'd2);
        check_val("t3_a0", wr_addr_log[base],     32'h400);
        check_val("t3_d0", wr_data_log[base],     32'hA);
        check_val("t3_a1", wr_addr_log[base + 1], 32'h404);
        check_val("t3_d1", wr_data_log[base + 1], 32'hB);
        tick();

        // Source pointer wraps; low address bits are forced to zero.
        init_mem[1023] = 32'h11;
        init_mem[0]    = 32'h22;
        base = wr_cnt;
        do_start(32'hFFFF_FFFE, 32'h503, 16'd2);
        check_val("t4_rd0", bus_addr, 32'hFFFF_FFFC);
        tick();
        check_val("t4_wr0", bus_addr, 32'h500);
        tick();
        check_val("t4_rd1",    bus_addr, 32'h0);
        check_val("t4_rd1_st", {31'd0, bus_mem_read}, 32'd1);
        wait_done(3, cyc);
        check_val("t4_d0", wr_data_log[base],     32'h11);
        check_val("t4_a1", wr_addr_log[base + 1], 32'h504);
        check_val("t4_d1", wr_data_log[base + 1], 32'h22);
        tick();

        // Start ignored while busy and in DONE; completion beats irq_clear.
        pulse_irq_clear();
        init_mem[384] = 32'h77;
        base = wr_cnt;
        do_start(32'h600, 32'h700, 16'd1);
        src_addr   = 32'h100;
        dst_addr   = 32'h200;
        word_count = 16'd3;
        start      = 1'b1;
        tick();
        start = 1'b0;
        check_val("t6_dst_kept", bus_addr, 32'h700);
        tick();
        check_val("t6_done", {31'd0, done}, 32'd1);
        start     = 1'b1;
        irq_clear = 1'b1;
        tick();
        start     = 1'b0;
        irq_clear = 1'b0;
        check_val("t6_irq_set", {31'd0, irq}, 32'd1);
        check_val("t6_idle",    {31'd0, busy}, 32'd0);
        check_val("t6_nwr",     wr_cnt - base, 32'd1);
        check_val("t6_data",    wr_data_log[base], 32'h77);
        tick();

`ifdef COPY_CHECKSUM_EN
        init_mem[512] = 32'd5;
        init_mem[513] = 32'hFFFF_FFFF;
        do_start(32'h800, 32'hB00, 16'd2);
        wait_done(1, cyc);
        check_val("cs_done", checksum, 32'd4);
        tick();
        check_val("cs_hold", checksum, 32'd4);
`endif

        // Reset during the second write of a 4-word copy.
        init_mem[576] = 32'd1;
        init_mem[577] = 32'd2;
        init_mem[578] = 32'd3;
        init_mem[579] = 32'd4;
        base = wr_cnt;
        do_start(32'h900, 32'hA00, 16'd4);
        tick();
        tick();
        tick();
        check_val("t5_pre_wr",   {31'd0, bus_mem_write}, 32'd1);
        check_val("t5_pre_data", bus_wr_data, 32'd2);
        reset = 1'b1;
        #1;
        check_val("t5_wr_off", {31'd0, bus_mem_write}, 32'd0);
        check_val("t5_addr0",  bus_addr, 32'h0);
        check_val("t5_wdata0", bus_wr_data, 32'h0);
        check_val("t5_busy0",  {31'd0, busy}, 32'd0);
        check_val("t5_irq0",   {31'd0, irq}, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        s0 = strobe_cnt;
        tick();
        tick();
        check_val("t5_nwr",     wr_cnt - base, 32'd1);
        check_val("t5_a0",      wr_addr_log[base], 32'hA00);
        check_val("t5_d0",      wr_data_log[base], 32'd1);
        check_val("t5_idle",    {31'd0, busy}, 32'd0);
        check_val("t5_no_done", {31'd0, done}, 32'd0);
        check_val("t5_quiet",   strobe_cnt - s0, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
